uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Receives a program image over UART (8N1) on the programmer clock domain, parses a length-prefixed frame, and produces the word-write stream consumed by InstructionMemory and DataMemory: write enable, 15-bit address (bit 14 selects data memory), 32-bit data, and a done flag. It sits directly upstream of both memories' `iUpg*` ports. It is the in-house replacement for the vendor programmer IP.

## Interface
Parameters:
- CLKS_PER_BIT, 87, `iUpgClock` cycles per UART bit (10 MHz / 115200); must be ≥ 4.
- MAX_WORDS, 16384, per-memory word capacity; word counts above this are errors.

Ports:
- iUpgClock  in  1  programmer clock; all logic on rising edge.
- iUpgReset  in  1  asynchronous, active-high reset.
- iUartRx  in  1  serial line from PC; idle high; asynchronous to `iUpgClock`.
- oUpgWriteEnable  out  1  one-cycle write strobe.
- oUpgAddress  out  15  [14]=0 instruction memory, 1 data memory; [13:0] word index.
- oUpgWriteData  out  32  word to write.
- oUpgDone  out  1  sticky; image fully loaded.
- oLoadError  out  1  sticky; framing or length error.

## Operation
- **Frame format** (all fields little-endian):
  - ICOUNT: 2 bytes, instruction word count.
  - ICOUNT words, 4 bytes each.
  - DCOUNT: 2 bytes, data word count.
  - DCOUNT words, 4 bytes each.
- **Input synchronizer:** `iUartRx` passes through a 2-flop synchronizer; both flops reset to 1.
- **Receiver:**
  - Idle until the synchronized line goes low, then wait CLKS_PER_BIT/2 cycles and re-sample.
  - If the line is high at that point: false start; return to idle, no error.
  - Otherwise sample 8 data bits LSB-first at CLKS_PER_BIT intervals, then the stop bit.
  - Stop bit = 1: emit an internal byte-valid pulse in the stop-sample cycle.
  - Stop bit = 0: framing error.
- **Parser states:**
  - HDR_I: collect 2 bytes into ICOUNT.
    - ICOUNT > MAX_WORDS → ERROR.
    - ICOUNT = 0 → HDR_D.
    - Otherwise → WORD_I.
  - WORD_I: assemble 4 bytes (first byte → bits[7:0]).
    - On the 4th byte, issue a write at address {1'b0, widx}, then widx++.
    - When widx reaches ICOUNT, clear widx and go to HDR_D.
  - HDR_D: collect DCOUNT with the same checks.
    - DCOUNT = 0 → DONE.
    - Otherwise → WORD_D.
  - WORD_D: as WORD_I with address {1'b1, widx}.
    - After DCOUNT words → DONE.
  - DONE: `oUpgDone`=1; further bytes ignored.
  - ERROR: `oLoadError`=1; further bytes ignored; `oUpgDone` stays 0.
- **Exiting DONE/ERROR:** only `iUpgReset` leaves either state.
- **Framing error:** from any non-DONE state → ERROR.
- **Byte counter:** 2-bit, clears on every state change.
- **Word index:** 14-bit; never exceeds MAX_WORDS−1 by construction.

## Timing
- **Reset values:** all outputs 0; parser in HDR_I; receiver idle; counters 0.
- **Byte latency:** byte-valid occurs ≈ 9.5·CLKS_PER_BIT cycles after the start edge (+2 synchronizer cycles).
- **Write strobe:** `oUpgWriteEnable` is high exactly one cycle, the cycle after the 4th byte's byte-valid.
- **Address/data hold:** `oUpgAddress`/`oUpgWriteData` are valid in that cycle and held until the next write.
- **Done timing:**
  - `oUpgDone` rises one cycle after the final write strobe.
  - If DCOUNT = 0, it rises one cycle after the 2nd DCOUNT byte-valid.
- **Error timing:** `oLoadError` rises the cycle after the offending stop sample or count byte.
- **Asynchronous reset mid-frame:** all outputs clear immediately; any partial word is discarded; the next byte is treated as ICOUNT low byte.
- **Back-to-back bytes** (no idle between stop and next start) are received correctly.

## Test plan
- **Normal load:** ICOUNT=2, words 0x12345678, 0xDEADBEEF, DCOUNT=1, word 0x0000002A.
  - Required: strobes at addresses 0x0000, 0x0001, 0x4000 with those data.
  - `oUpgDone`=1 one cycle after the third strobe.
- **Empty image:** ICOUNT=0, DCOUNT=0 → no strobes; `oUpgDone`=1 one cycle after the 4th byte.
- **Length error:** ICOUNT bytes 0x01, 0x40 (16385) → `oLoadError`=1; subsequent bytes produce no strobes; `oUpgDone`=0.
- **Line faults:**
  - Stop bit forced 0 on the 3rd byte of the first word → ERROR, no strobe.
  - A 0.3-bit low glitch on idle line → no byte received, no error.
- **Reset mid-word:** assert `iUpgReset` after 2 of 4 bytes.
  - Required: outputs 0 immediately.
  - Then a complete frame ICOUNT=1, 0xCAFEF00D, DCOUNT=0 writes address 0x0000 = 0xCAFEF00D and sets done.
- **Baud tolerance:** sender at +2% and −2% of nominal bit period with back-to-back bytes; 8-word image → all 8 words correct.

Source files
------------

// File: rtl/uart_program_loader_if.sv
// Word-write stream from the UART program loader to the instruction/data memories,
// plus the serial input line that feeds it.
interface uart_program_loader_if;
    logic        iUartRx;
    logic        oUpgWriteEnable;
    logic [14:0] oUpgAddress;
    logic [31:0] oUpgWriteData;
    logic        oUpgDone;
    logic        oLoadError;

    modport master (
        input  iUartRx,
        output oUpgWriteEnable,
        output oUpgAddress,
        output oUpgWriteData,
        output oUpgDone,
        output oLoadError
    );

    modport slave (
        output iUartRx,
        input  oUpgWriteEnable,
        input  oUpgAddress,
        input  oUpgWriteData,
        input  oUpgDone,
        input  oLoadError
    );
endinterface

// File: rtl/uart_program_loader.sv
// 8N1 UART receiver plus a length-prefixed frame parser that emits word writes
// for instruction memory (address bit 14 = 0) and data memory (bit 14 = 1).
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned MAX_WORDS    = 16384
) (
    input logic                   iUpgClock,
    input logic                   iUpgReset,
    uart_program_loader_if.master upg
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {PsHdrI, PsWordI, PsHdrD, PsWordD, PsDone, PsError} ps_state_e;

    logic            rx_meta_q, rx_sync_q;
    rx_state_e       rx_state_q;
    logic [CntW-1:0] clk_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;

    ps_state_e       ps_q;
    logic [1:0]      byte_cnt_q;
    logic [15:0]     count_q;
    logic [13:0]     widx_q;
    logic [31:0]     word_q;
    logic            we_q;
    logic [14:0]     addr_q;
    logic [31:0]     data_q;
    logic            done_q;
    logic            err_q;

    logic            stop_sample;
    logic            byte_valid;
    logic            frame_err;
    logic [15:0]     hdr_count;
    logic            hdr_too_big;
    logic            word_last;

    // Two-flop synchronizer; idle-high so reset must not fake a start bit.
    always_ff @(posedge iUpgClock or posedge iUpgReset) begin
        if (iUpgReset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= upg.iUartRx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge iUpgClock or posedge iUpgReset) begin
        if (iUpgReset) begin
            rx_state_q <= RxIdle;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            unique case (rx_state_q)
                RxIdle: begin
                    clk_cnt_q <= '0;
                    if (!rx_sync_q) begin
                        rx_state_q <= RxStart;
                    end
                end
                RxStart: begin
                    if (clk_cnt_q == HalfLast) begin
                        clk_cnt_q  <= '0;
                        bit_idx_q  <= '0;
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (clk_cnt_q == BitLast) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= RxStop;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (clk_cnt_q == BitLast) begin
                        clk_cnt_q  <= '0;
                        rx_state_q <= RxIdle;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    always_comb begin
        stop_sample = (rx_state_q == RxStop) && (clk_cnt_q == BitLast);
        byte_valid  = stop_sample && rx_sync_q;
        frame_err   = stop_sample && !rx_sync_q;
        hdr_count   = {shift_q, count_q[7:0]};
        hdr_too_big = (32'(hdr_count) > MAX_WORDS);
        word_last   = (({2'b00, widx_q} + 16'd1) == count_q);
    end

    always_ff @(posedge iUpgClock or posedge iUpgReset) begin
        if (iUpgReset) begin
            ps_q       <= PsHdrI;
            byte_cnt_q <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (frame_err && (ps_q != PsDone) && (ps_q != PsError)) begin
                ps_q       <= PsError;
                err_q      <= 1'b1;
                byte_cnt_q <= '0;
            end else if (byte_valid) begin
                unique case (ps_q)
                    PsHdrI, PsHdrD: begin
                        if (byte_cnt_q == 2'd0) begin
                            count_q[7:0] <= shift_q;
                            byte_cnt_q   <= 2'd1;
                        end else begin
                            count_q    <= hdr_count;
                            byte_cnt_q <= '0;
                            widx_q     <= '0;
                            if (hdr_too_big) begin
                                ps_q  <= PsError;
                                err_q <= 1'b1;
                            end else if (hdr_count == 16'd0) begin
                                if (ps_q == PsHdrI) begin
                                    ps_q <= PsHdrD;
                                end else begin
                                    ps_q   <= PsDone;
                                    done_q <= 1'b1;
                                end
                            end else begin
                                ps_q <= (ps_q == PsHdrI) ? PsWordI : PsWordD;
                            end
                        end
                    end
                    PsWordI, PsWordD: begin
                        // Little-endian: shifting down leaves the first byte in [7:0].
                        word_q     <= {shift_q, word_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            we_q   <= 1'b1;
                            addr_q <= {ps_q == PsWordD, widx_q};
                            data_q <= {shift_q, word_q[31:8]};
                            if (word_last) begin
                                widx_q <= '0;
                                ps_q   <= (ps_q == PsWordI) ? PsHdrD : PsDone;
                            end else begin
                                widx_q <= widx_q + 14'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // Entering DONE via a final write raises done one cycle after the strobe.
            if (ps_q == PsDone) begin
                done_q <= 1'b1;
            end
        end
    end

    assign upg.oUpgWriteEnable = we_q;
    assign upg.oUpgAddress     = addr_q;
    assign upg.oUpgWriteData   = data_q;
    assign upg.oUpgDone        = done_q;
    assign upg.oLoadError      = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised bench for uart_program_loader: a frame-level reference model fills a
// scoreboard of expected writes that a negedge monitor consumes.
module tb_uart_program_loader;

    localparam int unsigned Cpb      = 16;
    localparam int unsigned MaxWords = 16384;
    localparam int          ClkT     = 100;
    localparam int          BitNom   = 1600;

    typedef struct packed {
        logic [14:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_program_loader_if upg ();

    uart_program_loader #(
        .CLKS_PER_BIT(Cpb),
        .MAX_WORDS   (MaxWords)
    ) dut (
        .iUpgClock(clk),
        .iUpgReset(rst),
        .upg      (upg)
    );

    always #(ClkT / 2) clk = ~clk;

    wr_t        exp_q[$];
    logic [7:0] frame[$];
    int         checks = 0;
    int         errors = 0;
    longint     cyc = 0;
    longint     last_we_cyc = -1;
    longint     done_rise_cyc = -1;
    longint     last_stop_cyc = -1;
    bit         exp_done, exp_err, exp_dzero;
    logic       done_prev = 1'b0;
    wr_t        mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (upg.oUpgWriteEnable === 1'b1) begin
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                         upg.oUpgAddress, upg.oUpgWriteData);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 64'(upg.oUpgAddress), 64'(mon_e.addr));
                check("write_data", 64'(upg.oUpgWriteData), 64'(mon_e.data));
            end
        end
        if (upg.oUpgDone === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = upg.oUpgDone;
    end

    // Reference model: walk the byte stream as frame fields, stopping at the
    // first bad stop bit, an oversize count, or the end of the supplied bytes.
    task automatic run_model(input int bad);
        int  p = 0;
        int  n;
        int  cnt;
        bit  stop = 1'b0;
        n = frame.size();
        exp_done = 1'b0;
        exp_err = 1'b0;
        exp_dzero = 1'b0;
        for (int seg = 0; seg < 2 && !stop; seg++) begin
            if (bad >= 0 && bad < p + 2) begin
                exp_err = 1'b1;
                stop = 1'b1;
            end else if (n < p + 2) begin
                stop = 1'b1;
            end else begin
                cnt = int'(frame[p]) + 256 * int'(frame[p+1]);
                p += 2;
                if (cnt > int'(MaxWords)) begin
                    exp_err = 1'b1;
                    stop = 1'b1;
                end else begin
                    if (seg == 1 && cnt == 0) exp_dzero = 1'b1;
                    for (int w = 0; w < cnt && !stop; w++) begin
                        if (bad >= 0 && bad < p + 4) begin
                            exp_err = 1'b1;
                            stop = 1'b1;
                        end else if (n < p + 4) begin
                            stop = 1'b1;
                        end else begin
                            exp_q.push_back({seg[0], w[13:0],
                                             frame[p+3], frame[p+2], frame[p+1], frame[p]});
                            p += 4;
                        end
                    end
                end
            end
        end
        if (!stop) exp_done = 1'b1;
    endtask

    task automatic push_cnt(input int c);
        frame.push_back(c[7:0]);
        frame.push_back(c[15:8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) frame.push_back(w[8*i +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bit_t, input bit bad_stop);
        upg.iUartRx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            upg.iUartRx = b[i];
            #(bit_t);
        end
        last_stop_cyc = cyc;
        upg.iUartRx = !bad_stop;
        #(bit_t);
        upg.iUartRx = 1'b1;
    endtask

    task automatic send_frame(input int bit_t, input int bad, input int max_gap);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], bit_t, i == bad);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
        end
        repeat (3 * Cpb) @(posedge clk);
    endtask

    task automatic clear_tracking();
        exp_q.delete();
        last_we_cyc = -1;
        done_rise_cyc = -1;
        last_stop_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        upg.iUartRx = 1'b1;
        clear_tracking();
        repeat (3) @(posedge clk);
        #(ClkT / 5);
        rst = 1'b0;
        @(posedge clk);
        frame.delete();
    endtask

    task automatic finish_checks(input string name);
        check({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        check({name, "_done"}, 64'(upg.oUpgDone), 64'(exp_done));
        check({name, "_error"}, 64'(upg.oLoadError), 64'(exp_err));
        if (exp_done) begin
            if (!exp_dzero) begin
                check({name, "_done_timing"}, 64'(done_rise_cyc), 64'(last_we_cyc + 1));
            end else begin
                check({name, "_done_window"},
                      64'((done_rise_cyc > last_stop_cyc + Cpb / 4) &&
                          (done_rise_cyc <= last_stop_cyc + Cpb)), 64'd1);
            end
        end
    endtask

    task automatic run_case(input string name, input int bit_t, input int bad, input int gap);
        run_model(bad);
        send_frame(bit_t, bad, gap);
        finish_checks(name);
    endtask

    task automatic random_case(input string name, input int bit_t, input int ic, input int dc,
                               input bit allow_bad, input int gap);
        int bad = -1;
        do_reset();
        push_cnt(ic);
        repeat (ic) push_word($urandom);
        push_cnt(dc);
        repeat (dc) push_word($urandom);
        if (dc > 0) frame.push_back(8'($urandom));
        if (allow_bad && $urandom_range(0, 2) == 0) bad = int'($urandom_range(0, frame.size() - 1));
        run_case(name, bit_t, bad, gap);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_we"}, 64'(upg.oUpgWriteEnable), 64'd0);
        check({name, "_addr"}, 64'(upg.oUpgAddress), 64'd0);
        check({name, "_data"}, 64'(upg.oUpgWriteData), 64'd0);
        check({name, "_done"}, 64'(upg.oUpgDone), 64'd0);
        check({name, "_error"}, 64'(upg.oLoadError), 64'd0);
    endtask

    initial begin
        upg.iUartRx = 1'b1;
        do_reset();
        #1;
        check_outputs_zero("reset");

        // Normal load.
        frame.delete();
        push_cnt(2);
        push_word(32'h12345678);
        push_word(32'hDEADBEEF);
        push_cnt(1);
        push_word(32'h0000002A);
        run_case("normal", BitNom, -1, 0);

        // Empty image.
        do_reset();
        push_cnt(0);
        push_cnt(0);
        run_case("empty", BitNom, -1, 0);

        // ICOUNT = 16385 is one past capacity; trailing bytes must be ignored.
        do_reset();
        push_cnt(16385);
        push_cnt(1);
        push_word(32'h11223344);
        run_case("len_error", BitNom, -1, 0);

        // ICOUNT = 16384 is exactly at capacity and must be accepted.
        do_reset();
        push_cnt(16384);
        push_word(32'hA5A5_0001);
        run_case("len_max", BitNom, -1, 0);

        // Stop bit low on the third byte of the first word.
        do_reset();
        push_cnt(1);
        push_word(32'h44332211);
        push_cnt(0);
        run_case("stop_fault", BitNom, 4, 0);

        // 0.3-bit glitch on the idle line, then an empty image must still parse.
        do_reset();
        upg.iUartRx = 1'b0;
        #(BitNom * 3 / 10);
        upg.iUartRx = 1'b1;
        repeat (2 * Cpb) @(posedge clk);
        check("glitch_error", 64'(upg.oLoadError), 64'd0);
        push_cnt(0);
        push_cnt(0);
        run_case("glitch", BitNom, -1, 0);

        // Asynchronous reset after two bytes of the second word.
        do_reset();
        push_cnt(2);
        push_word(32'h44332211);
        frame.push_back(8'h55);
        frame.push_back(8'h66);
        run_case("pre_reset", BitNom, -1, 0);
        @(posedge clk);
        #(ClkT / 5);
        rst = 1'b1;
        #(ClkT / 10);
        check_outputs_zero("mid_reset");
        #(ClkT / 5);
        rst = 1'b0;
        clear_tracking();
        frame.delete();
        push_cnt(1);
        push_word(32'hCAFEF00D);
        push_cnt(0);
        run_case("after_reset", BitNom, -1, 0);

        // Baud tolerance, back-to-back bytes.
        random_case("baud_fast", BitNom * 98 / 100, 5, 3, 1'b0, 0);
        random_case("baud_slow", BitNom * 102 / 100, 5, 3, 1'b0, 0);

        for (int t = 0; t < 5; t++) begin
            random_case("random", BitNom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        1'b1, 12);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
